// File: rtl/dm_byte_mem.sv
// dm_byte_mem: word-organised data memory for the MEM stage.
//  - byte/half/word loads and stores, sign/zero extension on loads
//  - fixed RD_LAT response pipeline, stores and faults travel it too
//  - misaligned / illegal-size / out-of-range accesses fault with no side effect
//  - array is swept to zero after every reset before requests are accepted
// Optional build macro: DM_TRACE_EN (prints every committed store).
module dm_byte_mem #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic              state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [31:0]       mem [DEPTH];

    logic              acc;
    logic              err;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [31:0]       lane_word;
    logic [31:0]       ld_data;
    logic [31:0]       wd_rep;
    logic [31:0]       merged;
    logic [3:0]        be;
    rsp_t              rsp_in;

    logic [RD_LAT:1]   vld_pipe;
    rsp_t [RD_LAT:1]   rsp_pipe;

    assign req_ready = (state == ST_RUN);
    assign acc       = req_valid & req_ready;
    assign idx       = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];
    assign rd_word   = mem[idx];
    assign wr_en     = acc & req_we & ~err;

    // Fault decode: bad size, misalignment, or address bits above the decoded range.
    always_comb begin
        err = 1'b0;
        case (req_size)
            2'b01:   err = req_addr[0];
            2'b10:   err = |req_addr[1:0];
            2'b11:   err = 1'b1;
            default: err = 1'b0;
        endcase
        if ((req_addr >> ADDR_W) != 32'd0) err = 1'b1;
    end

    // Store merge: replicate right-aligned data across lanes, keep unaddressed lanes.
    always_comb begin
        be     = 4'b0000;
        wd_rep = req_wdata;
        merged = rd_word;
        case (req_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
    end

    // Load path: shift addressed lane down, then extend.
    always_comb begin
        lane_word = rd_word >> {lane, 3'b000};
        ld_data   = rd_word;
        case (req_size)
            2'b00:   ld_data = req_sign ? {{24{lane_word[7]}}, lane_word[7:0]}
                                        : {24'd0, lane_word[7:0]};
            2'b01:   ld_data = req_sign ? {{16{lane_word[15]}}, lane_word[15:0]}
                                        : {16'd0, lane_word[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    assign rsp_in.err  = err;
    assign rsp_in.data = (req_we | err) ? 32'd0 : ld_data;

    // Array writes: zero sweep while clearing, committed stores while running.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            mem[idx] <= merged;
    end

    // Clear-sweep FSM: one word per cycle, then hand over to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) state <= ST_RUN;
        end
    end

    // Response pipeline: idle stages carry zeros so outputs are clean without gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            rsp_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc;
            rsp_pipe[1] <= acc ? rsp_in : '0;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rsp_pipe[i] <= rsp_pipe[i-1];
            end
        end
    end

    assign rsp_valid = vld_pipe[RD_LAT];
    assign rsp_rdata = rsp_pipe[RD_LAT].data;
    assign rsp_err   = rsp_pipe[RD_LAT].err;

`ifdef DM_TRACE_EN
    // Store trace at the commit edge.
    always_ff @(posedge clk) begin
        if (wr_en)
            $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule
